// File: rtl/conv_fsm_pkg.sv
// conv_pkg: definitions shared by the convolution sequencing controller.
//   conv_state_t      controller state encoding
//   CONV_NB_ADDRESS   default memory address width (rows per block = 2^width)
//   CONV_M_LEN        default kernel length (kernel-load cycles)
//   CONV_PIPE_LAT     default convolver latency (write address lag, >= 1)
//   CONV_N_BLOCKS     default column blocks per frame (>= 1)
package conv_pkg;

    localparam int CONV_NB_ADDRESS = 4;
    localparam int CONV_M_LEN      = 3;
    localparam int CONV_PIPE_LAT   = 3;
    localparam int CONV_N_BLOCKS   = 2;

    typedef enum logic [2:0] {
        IDLE,
        KLOAD,
        RUN,
        DRAIN,
        CHBLK
    } conv_state_t;

    // Block counter width: clog2(n_blocks), never narrower than one bit.
    function automatic int blk_width(input int n_blocks);
        return (n_blocks > 1) ? $clog2(n_blocks) : 1;
    endfunction

endpackage

// File: rtl/conv_fsm_if.sv
// conv_fsm_if: command and sequencing signals of the convolution controller.
//   i_start, i_next      GPIO level commands from the soft microcontroller
//   o_raddr, o_waddr     memory read / write addresses (NB_ADDRESS bits)
//   o_wvalid             result write qualifier
//   o_sop, o_eop         frame in progress / idle (LED)
//   o_chblk              one-cycle block-change pulse
//   o_valid, o_ki        convolver input valid, kernel(1)/image(0) select
//   o_frame_cnt          completed-frame counter, only with CONV_FSM_FRAME_CNT_EN
// Modports: master = command source / observer, slave = the controller.
interface conv_fsm_if
    import conv_pkg::*;
#(
    parameter int NB_ADDRESS = CONV_NB_ADDRESS
);
    logic                  i_start;
    logic                  i_next;
    logic [NB_ADDRESS-1:0] o_raddr;
    logic [NB_ADDRESS-1:0] o_waddr;
    logic                  o_wvalid;
    logic                  o_sop;
    logic                  o_eop;
    logic                  o_chblk;
    logic                  o_valid;
    logic                  o_ki;
`ifdef CONV_FSM_FRAME_CNT_EN
    logic [15:0]           o_frame_cnt;
`endif

    modport master (
        output i_start, i_next,
        input  o_raddr, o_waddr, o_wvalid, o_sop, o_eop, o_chblk, o_valid, o_ki
`ifdef CONV_FSM_FRAME_CNT_EN
        , input o_frame_cnt
`endif
    );

    modport slave (
        input  i_start, i_next,
        output o_raddr, o_waddr, o_wvalid, o_sop, o_eop, o_chblk, o_valid, o_ki
`ifdef CONV_FSM_FRAME_CNT_EN
        , output o_frame_cnt
`endif
    );

endinterface

// File: rtl/conv_fsm_edge_det.sv
// edge_det: rising-edge detector for a GPIO level.
//   clk, rst   clock, synchronous active-high reset
//   d          level input
//   rise       high in the cycle where d is high and was low one cycle earlier
// The previous-level register resets to 1 so a level already held high
// through reset is not mistaken for a fresh edge.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b1;
        end else begin
            prev <= d;
        end
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/conv_fsm.sv
// conv_fsm: sequencing controller for the convolution datapath.
// Turns start / next-data GPIO edges into per-cycle read/write addresses,
// frame framing (sop/eop/chblk), convolver valid and kernel/image select.
// A frame is a kernel load (M_LEN cycles) followed by N_BLOCKS column blocks,
// each a RUN of 2^NB_ADDRESS reads and a DRAIN of PIPE_LAT trailing writes,
// with a one-cycle CHBLK between blocks.
//   CLK100MHZ  clock
//   rst        synchronous active-high reset
//   bus        conv_fsm_if.slave (commands in, sequencing outputs)
// Optional build macro CONV_FSM_FRAME_CNT_EN adds the 16-bit o_frame_cnt,
// incremented on every DRAIN->IDLE transition.
// PIPE_LAT must be at least 1 and M_LEN at most 2^NB_ADDRESS.
module conv_fsm
    import conv_pkg::*;
#(
    parameter int NB_ADDRESS = CONV_NB_ADDRESS,
    parameter int M_LEN      = CONV_M_LEN,
    parameter int PIPE_LAT   = CONV_PIPE_LAT,
    parameter int N_BLOCKS   = CONV_N_BLOCKS
) (
    input logic       CLK100MHZ,
    input logic       rst,
    conv_fsm_if.slave bus
);
    localparam int BLK_W = blk_width(N_BLOCKS);

    localparam logic [NB_ADDRESS-1:0] ADDR_MAX   = {NB_ADDRESS{1'b1}};
    localparam logic [NB_ADDRESS-1:0] KLOAD_LAST = NB_ADDRESS'(M_LEN - 1);
    localparam logic [NB_ADDRESS-1:0] LAT        = NB_ADDRESS'(PIPE_LAT);
    localparam logic [BLK_W-1:0]      BLK_LAST   = BLK_W'(N_BLOCKS - 1);

    conv_state_t           state;
    logic [BLK_W-1:0]      blk_cnt;
    logic [NB_ADDRESS-1:0] k_next;
    logic                  start_rise;
    logic                  next_rise;

    edge_det u_start_edge (
        .clk  (CLK100MHZ),
        .rst  (rst),
        .d    (bus.i_start),
        .rise (start_rise)
    );

    edge_det u_next_edge (
        .clk  (CLK100MHZ),
        .rst  (rst),
        .d    (bus.i_next),
        .rise (next_rise)
    );

    assign k_next = bus.o_raddr + NB_ADDRESS'(1);

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state        <= IDLE;
            blk_cnt      <= '0;
            bus.o_raddr  <= '0;
            bus.o_waddr  <= '0;
            bus.o_wvalid <= 1'b0;
            bus.o_sop    <= 1'b0;
            bus.o_eop    <= 1'b1;
            bus.o_chblk  <= 1'b0;
            bus.o_valid  <= 1'b0;
            bus.o_ki     <= 1'b1;
`ifdef CONV_FSM_FRAME_CNT_EN
            bus.o_frame_cnt <= '0;
`endif
        end else begin
            bus.o_chblk <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Start has priority over next when both edges coincide.
                    if (start_rise) begin
                        state       <= KLOAD;
                        blk_cnt     <= '0;
                        bus.o_raddr <= '0;
                        bus.o_waddr <= '0;
                        bus.o_valid <= 1'b1;
                        bus.o_ki    <= 1'b1;
                        bus.o_sop   <= 1'b1;
                        bus.o_eop   <= 1'b0;
                    end else if (next_rise) begin
                        bus.o_raddr <= k_next;
                    end
                end
                KLOAD: begin
                    if (bus.o_raddr == KLOAD_LAST) begin
                        state       <= RUN;
                        bus.o_raddr <= '0;
                        bus.o_ki    <= 1'b0;
                    end else begin
                        bus.o_raddr <= k_next;
                    end
                end
                RUN: begin
                    if (bus.o_raddr == ADDR_MAX) begin
                        state        <= DRAIN;
                        bus.o_valid  <= 1'b0;
                        bus.o_wvalid <= 1'b1;
                        bus.o_waddr  <= bus.o_waddr + NB_ADDRESS'(1);
                    end else begin
                        bus.o_raddr <= k_next;
                        // Write address trails the read address by the
                        // convolver latency and sits at 0 until it catches up.
                        if (k_next >= LAT) begin
                            bus.o_wvalid <= 1'b1;
                            bus.o_waddr  <= k_next - LAT;
                        end
                    end
                end
                DRAIN: begin
                    // The last in-flight result lands on the top row.
                    if (bus.o_waddr == ADDR_MAX) begin
                        bus.o_raddr  <= '0;
                        bus.o_waddr  <= '0;
                        bus.o_wvalid <= 1'b0;
                        if (blk_cnt != BLK_LAST) begin
                            state       <= CHBLK;
                            bus.o_chblk <= 1'b1;
                            blk_cnt     <= blk_cnt + BLK_W'(1);
                        end else begin
                            state     <= IDLE;
                            bus.o_sop <= 1'b0;
                            bus.o_eop <= 1'b1;
                            bus.o_ki  <= 1'b1;
`ifdef CONV_FSM_FRAME_CNT_EN
                            bus.o_frame_cnt <= bus.o_frame_cnt + 16'd1;
`endif
                        end
                    end else begin
                        bus.o_waddr <= bus.o_waddr + NB_ADDRESS'(1);
                    end
                end
                CHBLK: begin
                    // Kernel stays loaded; go straight to the next image block.
                    state       <= RUN;
                    bus.o_valid <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/conv_fsm.md
# conv_fsm

Sequencing controller for the convolution datapath. It replaces the hand-driven stimulus registers in front of the memory control unit, the convolver array and the column memories. It takes GPIO level commands from the soft microcontroller (start, next-data) and produces the per-cycle read/write addresses, frame framing (sop/eop/chblk), convolver valid and kernel/image select. One frame is processed as `N_BLOCKS` column blocks, each preceded on the first block by a kernel-load phase.

## Interface
- `NB_ADDRESS`, 4: memory address width; one block holds 2^NB_ADDRESS rows.
- `M_LEN`, 3: kernel length; number of kernel-load cycles.
- `PIPE_LAT`, 3: convolver latency, as the lag of the write address behind the read address.
- `N_BLOCKS`, 2: column blocks per frame (≥1).
- `CLK100MHZ`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `i_start`  in  1  GPIO level; rising edge starts a frame.
- `i_next`  in  1  GPIO level; rising edge advances the readback address while idle.
- `o_raddr`  out  NB_ADDRESS  memory read address.
- `o_waddr`  out  NB_ADDRESS  memory write address.
- `o_wvalid`  out  1  result write qualifier.
- `o_sop`  out  1  frame processing in progress.
- `o_eop`  out  1  idle / frame complete (LED).
- `o_chblk`  out  1  one-cycle block-change pulse.
- `o_valid`  out  1  convolver input valid.
- `o_ki`  out  1  convolver select: 1 = kernel, 0 = image.

## Operation
- States: IDLE, KLOAD, RUN, DRAIN, CHBLK. All outputs are registered.
- Reset values: state IDLE, `o_raddr`=0, `o_waddr`=0, `o_eop`=1, `o_ki`=1, all others 0.
- Edge detectors keep the previous level and reset it to 1, so a level already held high through reset does not trigger.
- IDLE: `o_eop`=1, `o_ki`=1.
  - A start edge loads `o_raddr`=0 and `o_waddr`=0 and enters KLOAD.
  - Otherwise a next edge increments `o_raddr` (wraps 2^NB_ADDRESS-1→0).
  - If both edges occur in the same cycle, start wins.
- KLOAD (M_LEN cycles): `o_valid`=1, `o_ki`=1, `o_sop`=1, `o_raddr`=0..M_LEN-1. Then `o_raddr`←0 and the state goes to RUN.
- RUN (2^NB_ADDRESS cycles): `o_valid`=1, `o_ki`=0, `o_sop`=1, `o_raddr`=k for k=0..2^NB_ADDRESS-1.
  - `o_waddr`=max(0,k-PIPE_LAT).
  - `o_wvalid`=1 when k≥PIPE_LAT.
- DRAIN (PIPE_LAT cycles): `o_valid`=0, `o_ki`=0, `o_wvalid`=1, `o_waddr` continues incrementing up to 2^NB_ADDRESS-1.
- At the end of DRAIN:
  - If the block counter < N_BLOCKS-1, go to CHBLK.
  - Otherwise go to IDLE with `o_raddr`=0 and `o_waddr`=0.
- CHBLK (1 cycle): `o_chblk`=1, `o_sop`=1, block counter +1, `o_raddr`=0, `o_waddr`=0, then RUN. The kernel is not reloaded.
- Start edges outside IDLE are ignored. Next edges outside IDLE are ignored.
- `rst` asserted in any state returns every output to its reset value on that edge.
- The block counter width is clog2(N_BLOCKS), minimum 1. It clears on entry to KLOAD.

## Timing
- Input edge at cycle t (level high, previous low) → state change visible on outputs at t+1.
- Frame length from the first KLOAD cycle to `o_eop`=1: M_LEN + N_BLOCKS·(2^NB_ADDRESS+PIPE_LAT) + (N_BLOCKS-1) cycles.
  - With the defaults this is 3+2·19+1 = 42. `o_eop` rises at cycle 42.
- `o_sop` and `o_eop` are mutually exclusive and never both 0 outside reset.
- Writes per block: exactly 2^NB_ADDRESS, to addresses 0..2^NB_ADDRESS-1 in order.

## Configuration
- `CONV_FSM_FRAME_CNT_EN` defined: adds output `o_frame_cnt` (16 bits). It resets to 0 and increments in the cycle of the DRAIN→IDLE transition, wrapping at 0xFFFF→0.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `conv_pkg` holds:
  - the state enum `conv_state_t`;
  - default constants `CONV_NB_ADDRESS`, `CONV_M_LEN`, `CONV_PIPE_LAT`, `CONV_N_BLOCKS`.
- One sub-module, `edge_det`: rising-edge detector with synchronous reset whose previous-level register resets to 1. It is instantiated for `i_start` and for `i_next`.

## Test plan
- Reset with `i_start`=1 held, then release → no frame starts; `o_eop`=1, `o_ki`=1, `o_raddr`=0.
- Start pulse with defaults:
  - KLOAD shows raddr 0,1,2 with ki=1.
  - RUN shows raddr 0..15 with waddr 0,0,0,0,1..12.
  - DRAIN shows waddr 13,14,15.
  - `o_chblk` pulses once; the second block repeats the sequence.
  - `o_eop` rises at cycle 42; 32 `o_wvalid` cycles in total.
- In IDLE, 17 `i_next` rising edges → `o_raddr` steps 1..15 then wraps 0, then 1. Level held high advances it only once.
- `i_start` edge at RUN raddr=7 → ignored. The same cycle also carries an `i_next` edge → ignored. Sequence unchanged.
- `rst` asserted at RUN raddr=9 → next cycle IDLE with all reset values. A new start runs a full 42-cycle frame.
- With `CONV_FSM_FRAME_CNT_EN`: three back-to-back frames → `o_frame_cnt` reads 1, 2, 3 in the cycle after each DRAIN→IDLE transition.
